// File: rtl/pwm_ramp_ctrl_if.sv
// Command/status bundle between the CSR block (master) and the ramp sequencer (slave).
interface pwm_ramp_ctrl_if #(
  parameter int W      = 16,
  parameter int HOLD_W = 16
);
  logic              start_i;
  logic              abort_i;
  logic [W-1:0]      period_i;
  logic [6:0]        duty_start_i;
  logic [6:0]        duty_end_i;
  logic [6:0]        duty_step_i;
  logic [HOLD_W-1:0] hold_i;
  logic [6:0]        duty_o;
  logic              busy_o;
  logic              done_o;
  logic              err_o;

  modport master (
    output start_i, abort_i, period_i, duty_start_i, duty_end_i, duty_step_i, hold_i,
    input  duty_o, busy_o, done_o, err_o
  );

  modport slave (
    input  start_i, abort_i, period_i, duty_start_i, duty_end_i, duty_step_i, hold_i,
    output duty_o, busy_o, done_o, err_o
  );
endinterface

// File: rtl/pwm_ramp_ctrl.sv
// Duty-cycle ramp sequencer driving a PWM counter's clr/ld/en strobes.
// Optional macro PWM_RAMP_SYNC_EN aligns each duty change to a rising edge of pwm_tc_i.
module pwm_ramp_ctrl #(
  parameter int W      = 16,
  parameter int HOLD_W = 16
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  pwm_ramp_ctrl_if.slave bus,
  input  logic           pwm_tc_i,
  output logic           pwm_en_o,
  output logic           pwm_clr_o,
  output logic           pwm_ld_o,
  output logic [W-1:0]   pwm_ld_val_o,
  output logic [W-1:0]   pwm_thr_o
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLR    = 3'd1,
    ST_LOAD   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_RUN    = 3'd4,
    ST_SYNC   = 3'd5,
    ST_STEADY = 3'd6,
    ST_ABORT  = 3'd7
  } state_e;

  localparam logic [6:0]        DUTY_MAX = 7'd100;
  localparam logic [W-1:0]      ONE_W    = W'(1);
  localparam logic [W-1:0]      TWO_W    = W'(2);
  localparam logic [HOLD_W-1:0] ONE_H    = HOLD_W'(1);

  state_e            state_r, state_n;
  logic [W-1:0]      period_r, period_n, tmr_r, tmr_n;
  logic [HOLD_W-1:0] hold_r, hold_n, hcnt_r, hcnt_n;
  logic [6:0]        duty_r, duty_n, end_r, end_n, step_r, step_n;
  logic [6:0]        duty_out_r, duty_out_n, nxt_duty_s;
  logic              err_n, adv_s, hold_exp_s;
  logic              busy_r, done_r, err_r;

  function automatic logic [6:0] clamp_duty(input logic [6:0] v);
    if (v > DUTY_MAX) begin
      clamp_duty = DUTY_MAX;
    end else begin
      clamp_duty = v;
    end
  endfunction

  // Rising ramps saturate at the end duty; falling ramps use 8 bits so d-s cannot wrap.
  function automatic logic [6:0] step_duty(input logic [6:0] d, input logic [6:0] e,
                                           input logic [6:0] s);
    logic [7:0] sum_v;
    logic [7:0] dif_v;
    sum_v = {1'b0, d} + {1'b0, s};
    dif_v = {1'b0, d} - {1'b0, s};
    if (s == 7'd0) begin
      step_duty = e;
    end else if (e > d) begin
      step_duty = (sum_v > {1'b0, e}) ? e : sum_v[6:0];
    end else begin
      step_duty = (dif_v[7] || (dif_v < {1'b0, e})) ? e : dif_v[6:0];
    end
  endfunction

  assign nxt_duty_s = step_duty(duty_r, end_r, step_r);
  assign hold_exp_s = (tmr_r == (period_r - ONE_W)) &&
                      (({1'b0, hcnt_r} + {{HOLD_W{1'b0}}, 1'b1}) == {1'b0, hold_r});

`ifdef PWM_RAMP_SYNC_EN
  localparam logic [W:0] ONE_W1 = {{W{1'b0}}, 1'b1};
  logic [W:0] wait_r, wait_n;
  logic       tc_q_r, tc_rise_s;

  assign tc_rise_s = pwm_tc_i & ~tc_q_r;

  // Edge detector and post-hold wait counter for period-aligned duty changes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tc_q_r <= 1'b0;
      wait_r <= {(W+1){1'b0}};
    end else begin
      tc_q_r <= pwm_tc_i;
      wait_r <= wait_n;
    end
  end
`else
  logic unused_tc_s;
  assign unused_tc_s = pwm_tc_i;
`endif

  // Next-state, capture and counter logic; abort has priority over start.
  always_comb begin
    state_n    = state_r;
    period_n   = period_r;
    duty_n     = duty_r;
    end_n      = end_r;
    step_n     = step_r;
    hold_n     = hold_r;
    tmr_n      = tmr_r;
    hcnt_n     = hcnt_r;
    duty_out_n = duty_out_r;
    err_n      = 1'b0;
    adv_s      = 1'b0;
`ifdef PWM_RAMP_SYNC_EN
    wait_n     = wait_r;
`endif
    if (bus.abort_i && (state_r != ST_IDLE)) begin
      state_n    = ST_ABORT;
      duty_out_n = 7'd0;
      tmr_n      = {W{1'b0}};
      hcnt_n     = {HOLD_W{1'b0}};
    end else if (bus.start_i && ((state_r == ST_IDLE) || (state_r == ST_STEADY))) begin
      if (bus.period_i < TWO_W) begin
        err_n = 1'b1;
      end else begin
        state_n  = ST_CLR;
        period_n = bus.period_i;
        duty_n   = clamp_duty(bus.duty_start_i);
        end_n    = clamp_duty(bus.duty_end_i);
        step_n   = bus.duty_step_i;
        hold_n   = (bus.hold_i == {HOLD_W{1'b0}}) ? ONE_H : bus.hold_i;
        tmr_n    = {W{1'b0}};
        hcnt_n   = {HOLD_W{1'b0}};
      end
    end else begin
      case (state_r)
        ST_IDLE:   state_n = ST_IDLE;
        ST_CLR: begin
          state_n    = ST_LOAD;
          duty_out_n = duty_r;
        end
        ST_LOAD:   state_n = ST_SETTLE;
        ST_SETTLE: state_n = ST_RUN;
        ST_RUN: begin
          if (hold_exp_s) begin
`ifdef PWM_RAMP_SYNC_EN
            state_n = ST_SYNC;
            wait_n  = {(W+1){1'b0}};
`else
            adv_s   = 1'b1;
`endif
          end else if (tmr_r == (period_r - ONE_W)) begin
            tmr_n  = {W{1'b0}};
            hcnt_n = hcnt_r + ONE_H;
          end else begin
            tmr_n  = tmr_r + ONE_W;
          end
        end
        ST_SYNC: begin
`ifdef PWM_RAMP_SYNC_EN
          // Flat outputs (duty 0 or 100) never toggle, so give up after two periods.
          if (tc_rise_s || (wait_r == (({1'b0, period_r} << 1) - ONE_W1))) begin
            adv_s = 1'b1;
          end else begin
            wait_n = wait_r + ONE_W1;
          end
`else
          state_n = ST_IDLE;
`endif
        end
        ST_STEADY: state_n = ST_STEADY;
        ST_ABORT:  state_n = ST_IDLE;
        default:   state_n = ST_IDLE;
      endcase
      if (adv_s) begin
        tmr_n  = {W{1'b0}};
        hcnt_n = {HOLD_W{1'b0}};
        if (duty_r == end_r) begin
          state_n = ST_STEADY;
        end else begin
          state_n    = ST_LOAD;
          duty_n     = nxt_duty_s;
          duty_out_n = nxt_duty_s;
        end
      end else begin
        state_n = state_n;
      end
    end
  end

  // State, captured configuration and registered strobes decoded from the next state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r      <= ST_IDLE;
      period_r     <= {W{1'b0}};
      duty_r       <= 7'd0;
      end_r        <= 7'd0;
      step_r       <= 7'd0;
      hold_r       <= {HOLD_W{1'b0}};
      tmr_r        <= {W{1'b0}};
      hcnt_r       <= {HOLD_W{1'b0}};
      duty_out_r   <= 7'd0;
      pwm_en_o     <= 1'b0;
      pwm_clr_o    <= 1'b0;
      pwm_ld_o     <= 1'b0;
      pwm_ld_val_o <= {W{1'b0}};
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      state_r      <= state_n;
      period_r     <= period_n;
      duty_r       <= duty_n;
      end_r        <= end_n;
      step_r       <= step_n;
      hold_r       <= hold_n;
      tmr_r        <= tmr_n;
      hcnt_r       <= hcnt_n;
      duty_out_r   <= duty_out_n;
      pwm_en_o     <= (state_n == ST_RUN) || (state_n == ST_SYNC) || (state_n == ST_STEADY);
      pwm_clr_o    <= (state_n == ST_CLR) || (state_n == ST_ABORT);
      pwm_ld_o     <= (state_n == ST_LOAD);
      pwm_ld_val_o <= (state_n == ST_LOAD) ? {{(W-7){1'b0}}, duty_out_n} : pwm_ld_val_o;
      busy_r       <= (state_n == ST_CLR) || (state_n == ST_LOAD) || (state_n == ST_SETTLE) ||
                      (state_n == ST_RUN) || (state_n == ST_SYNC);
      done_r       <= (state_n == ST_STEADY) && (state_r != ST_STEADY);
      err_r        <= err_n;
    end
  end

  assign pwm_thr_o   = period_r;
  assign bus.duty_o  = duty_out_r;
  assign bus.busy_o  = busy_r;
  assign bus.done_o  = done_r;
  assign bus.err_o   = err_r;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Randomized bench for pwm_ramp_ctrl: a duty-list/timeline model predicts every cycle's outputs.
module tb_pwm_ramp_ctrl;
  localparam int W  = 16;
  localparam int HW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pwm_tc = 1'b0;
  logic          pwm_en, pwm_clr, pwm_ld;
  logic [W-1:0]  pwm_ld_val, pwm_thr;

  int            total = 0;
  int            bad = 0;
  logic [12:0]   exp_q[$];
  int            busy_len;
  logic [12:0]   cur_vec = 13'd0;
  int            prev_duty = 0;
  int            thr_model = 0;

  pwm_ramp_ctrl_if #(.W(W), .HOLD_W(HW)) ifc();

  pwm_ramp_ctrl #(.W(W), .HOLD_W(HW)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .bus          (ifc),
    .pwm_tc_i     (pwm_tc),
    .pwm_en_o     (pwm_en),
    .pwm_clr_o    (pwm_clr),
    .pwm_ld_o     (pwm_ld),
    .pwm_ld_val_o (pwm_ld_val),
    .pwm_thr_o    (pwm_thr)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Vector layout: {en, clr, ld, busy, done, err, duty[6:0]}
  function automatic logic [12:0] pk(input bit en, input bit clr, input bit ld, input bit busy,
                                     input bit done, input bit err, input int duty);
    logic [31:0] d;
    d = duty;
    return {en, clr, ld, busy, done, err, d[6:0]};
  endfunction

  function automatic logic [12:0] obs();
    return {pwm_en, pwm_clr, pwm_ld, ifc.busy_o, ifc.done_o, ifc.err_o, ifc.duty_o};
  endfunction

  function automatic int clampi(input int v);
    return (v > 100) ? 100 : v;
  endfunction

  // Timeline: CLR, then per duty LOAD + SETTLE + hold*period RUN cycles, then STEADY.
  function automatic void build_trace(input int per, input int ds, input int de, input int dst,
                                      input int h, input int prev);
    int d, e, hh;
    d = clampi(ds);
    e = clampi(de);
    hh = (h == 0) ? 1 : h;
    exp_q.delete();
    exp_q.push_back(pk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, prev));
    while (1'b1) begin
      exp_q.push_back(pk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, d));
      exp_q.push_back(pk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, d));
      for (int i = 0; i < hh * per; i++) exp_q.push_back(pk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, d));
      if (d == e) break;
      if (dst == 0) d = e;
      else if (e > d) d = (d + dst > e) ? e : d + dst;
      else d = (d - dst < e) ? e : d - dst;
    end
    busy_len = exp_q.size();
    exp_q.push_back(pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, e));
    for (int i = 0; i < 3; i++) exp_q.push_back(pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e));
  endfunction

  task automatic drive_start(input int per, input int ds, input int de, input int dst, input int h);
    ifc.period_i     = W'(per);
    ifc.duty_start_i = 7'(ds);
    ifc.duty_end_i   = 7'(de);
    ifc.duty_step_i  = 7'(dst);
    ifc.hold_i       = HW'(h);
    ifc.start_i      = 1'b1;
    @(negedge clk);
    ifc.start_i      = 1'b0;
  endtask

  task automatic run_ramp(input int per, input int ds, input int de, input int dst, input int h,
                          input int abort_at, input int xstart_at);
    build_trace(per, ds, de, dst, h, prev_duty);
    drive_start(per, ds, de, dst, h);
    thr_model = per;
    check_val("thr", 32'(pwm_thr), 32'(thr_model));
    for (int k = 0; k < exp_q.size(); k++) begin
      check_val("trace", 32'(obs()), 32'(exp_q[k]));
      if (exp_q[k][10]) check_val("ldval", 32'(pwm_ld_val), 32'(exp_q[k][6:0]));
      if (k == abort_at) begin
        ifc.abort_i = 1'b1;
        @(negedge clk);
        ifc.abort_i = 1'b0;
        check_val("abort_clr", 32'(obs()), 32'(pk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0)));
        @(negedge clk);
        check_val("abort_idle", 32'(obs()), 32'd0);
        prev_duty = 0;
        cur_vec   = 13'd0;
        return;
      end
      if ((k == xstart_at) && (k < busy_len)) begin
        ifc.period_i     = W'($urandom_range(2, 50));
        ifc.duty_start_i = 7'($urandom_range(0, 127));
        ifc.duty_end_i   = 7'($urandom_range(0, 127));
        ifc.start_i      = 1'b1;
      end
      @(negedge clk);
      ifc.start_i = 1'b0;
    end
    prev_duty = clampi(de);
    cur_vec   = pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, prev_duty);
  endtask

  task automatic reject(input int per);
    ifc.period_i     = W'(per);
    ifc.duty_start_i = 7'($urandom_range(0, 127));
    ifc.duty_end_i   = 7'($urandom_range(0, 127));
    ifc.start_i      = 1'b1;
    @(negedge clk);
    ifc.start_i      = 1'b0;
    check_val("err", 32'(obs()), 32'(cur_vec | 13'h080));
    check_val("thr_keep", 32'(pwm_thr), 32'(thr_model));
    @(negedge clk);
    check_val("post_err", 32'(obs()), 32'(cur_vec));
  endtask

  initial begin
    ifc.start_i = 1'b0;
    ifc.abort_i = 1'b0;
    ifc.period_i = '0;
    ifc.duty_start_i = 7'd0;
    ifc.duty_end_i = 7'd0;
    ifc.duty_step_i = 7'd0;
    ifc.hold_i = '0;
    #12;
    check_val("rst_out", 32'(obs()), 32'd0);
    check_val("rst_thr", 32'(pwm_thr), 32'd0);
    check_val("rst_ldval", 32'(pwm_ld_val), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_ramp(10, 20, 50, 10, 2, -1, -1);
    reject(0);
    run_ramp(10, 30, 5, 20, 2, -1, -1);
    run_ramp(10, 20, 50, 10, 2, 23, -1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("idle", 32'(obs()), 32'd0);
    end
    reject(1);
    run_ramp(10, 0, 120, 0, 0, -1, -1);
    run_ramp(6, 40, 40, 5, 1, -1, 4);

    for (int it = 0; it < 8; it++) begin
      int per, ds, de, dst, h, ab, xs;
      per = $urandom_range(2, 9);
      ds  = $urandom_range(0, 127);
      de  = $urandom_range(0, 127);
      dst = $urandom_range(0, 40);
      h   = $urandom_range(0, 3);
      ab  = -1;
      xs  = -1;
      if ($urandom_range(0, 3) == 0) ab = $urandom_range(0, 60);
      if ($urandom_range(0, 1) == 1) xs = $urandom_range(0, 30);
      if ($urandom_range(0, 3) == 0) reject($urandom_range(0, 1));
      run_ramp(per, ds, de, dst, h, ab, xs);
    end

    drive_start(10, 20, 50, 10, 2);
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("async_rst_out", 32'(obs()), 32'd0);
    check_val("async_rst_thr", 32'(pwm_thr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("post_rst_idle", 32'(obs()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
